tc_mod_acc: RTL and testbench
=============================

TC_MOD_ACC -- requirements
Module: tc_mod_acc

Interface
REQ-001 SHALL have parameter M, default 11, meaning residue modulus, legal range 3..64.
REQ-002 SHALL have derived localparam W, default clog2(M)=4, meaning binary residue width; TCW = M-1, meaning thermometer width.
REQ-003 SHALL have port clk  input  1  sole clock, all flops on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input beat offered.
REQ-006 SHALL have port in_ready  output  1  input beat accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_data  input  W  binary residue addend.
REQ-008 SHALL have port in_clr  input  1  beat starts a new sum (accumulator treated as 0 before adding).
REQ-009 SHALL have port out_valid  output  1  result beat offered.
REQ-010 SHALL have port out_ready  input  1  result beat consumed when out_valid&&out_ready.
REQ-011 SHALL have port out_tc  output  TCW  running sum mod M, thermometer code (value v -> bits [v-1:0] set, rest 0).
REQ-012 SHALL have port out_bin  output  W  same running sum, binary.
REQ-013 SHALL have port out_wrap  output  1  this beat's addition reached or exceeded M.
REQ-014 SHALL have port out_err  output  1  this beat's in_data was >= M.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 registers thermometer-encoded addend plus clr/err flags; S2 performs modular add, updates accumulator, registers outputs.
REQ-016 SHALL produce out_valid exactly 2 cycles after acceptance when out_ready held high; throughput 1 beat/cycle.
REQ-017 SHALL stall both stages whenever out_valid && !out_ready; in_ready = !(out_valid && !out_ready); no beat lost or duplicated.
REQ-018 SHALL hold out_tc, out_bin, out_wrap, out_err stable while out_valid && !out_ready.
REQ-019 SHALL encode in_data >= M as addend 0 and set out_err for that beat only (not sticky).
REQ-020 SHALL compute sum s = base + addend, base = 0 if clr else accumulator; if s >= M result = s-M and out_wrap=1, else result = s and out_wrap=0.
REQ-021 SHALL perform the addition in thermometer domain (shift-in of ones by addend, overflow detected from bit TCW-1 spill) and derive out_bin by popcount of the result.
REQ-022 SHALL update the accumulator only when a beat advances into S2; bubbles leave it unchanged.
REQ-023 SHALL guarantee out_bin equals popcount(out_tc) and out_tc is always a legal thermometer code.
REQ-024 SHALL treat in_clr on a beat with in_data >= M as result 0, out_err=1, out_wrap=0.

Reset
REQ-025 SHALL, when rst high at a clock edge, clear accumulator to 0, S1/S2 valid to 0, out_valid=0, out_tc=0, out_bin=0, out_wrap=0, out_err=0.
REQ-026 SHALL discard any in-flight beats on reset mid-operation; first post-reset beat sums from 0 regardless of in_clr.
REQ-027 SHALL drive in_ready=1 during and immediately after reset (out_valid is 0).

Structure
REQ-028 SHALL place modulus default, clog2 function and TCW/W width derivations in shared package rns_pkg.
REQ-029 SHALL instantiate one sub-module tc_encode (parametrised binary-to-thermometer converter, out-of-range -> 0 plus err flag) in S1.
REQ-030 SHALL target 120-400 lines RTL total, no memories, no multi-cycle paths.

Verification
REQ-031 SHALL cover M=11: clr beat 3, then 4, 5 -> out_bin 3,7,1; out_tc 0000000111, 0001111111, 0000000001; out_wrap 0,0,1.
REQ-032 SHALL cover M=11: clr beat 10, then 10 -> out_bin 10 then 9, out_tc 1111111111 then 0111111111, out_wrap on second only.
REQ-033 SHALL cover M=11: in_data 13 after sum 6 -> out_bin 6, out_err 1, next beat 2 -> out_bin 8, out_err 0.
REQ-034 SHALL cover backpressure: out_ready low 3 cycles with beats pending -> in_ready low, outputs stable, sequence of sums unchanged after release.
REQ-035 SHALL cover rst asserted with 2 beats in flight -> out_valid 0 next cycle, next beat 5 (no clr) -> out_bin 5.
REQ-036 SHALL cover M=3 and M=64 random streams against a reference model of (sum mod M), checking wrap, err and popcount consistency.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared modulus default and width helpers
// for residue-number-system blocks.
package rns_pkg;

  localparam int M_DEFAULT = 11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int tc_width(input int m);
    return m - 1;
  endfunction

endpackage

// File: rtl/tc_encode.sv
// Binary residue to thermometer converter;
// out-of-range inputs map to zero with err set.
module tc_encode
  import rns_pkg::*;
#(
  parameter  int M   = M_DEFAULT,
  localparam int W   = clog2(M),
  localparam int TCW = tc_width(M)
) (
  input  logic [W-1:0]   bin,
  output logic [TCW-1:0] tc,
  output logic           err
);

  always_comb begin
    err = 32'(bin) >= 32'(M);
    tc  = '0;
    for (int i = 0; i < TCW; i++) begin
      tc[i] = !err && (32'(i) < 32'(bin));
    end
  end

endmodule

// File: rtl/tc_mod_acc.sv
// Two-stage modular accumulator working in
// the thermometer domain with valid/ready flow.
module tc_mod_acc
  import rns_pkg::*;
#(
  parameter  int M   = M_DEFAULT,
  localparam int W   = clog2(M),
  localparam int TCW = tc_width(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [TCW-1:0] out_tc,
  output logic [W-1:0]   out_bin,
  output logic           out_wrap,
  output logic           out_err
);

  logic [TCW-1:0] enc_tc;
  logic           enc_err;

  logic           s1_vld_q, s1_vld_d;
  logic [TCW-1:0] s1_tc_q, s1_tc_d;
  logic           s1_clr_q, s1_clr_d;
  logic           s1_err_q, s1_err_d;

  logic           out_vld_q, out_vld_d;
  logic [TCW-1:0] out_tc_q, out_tc_d;
  logic [W-1:0]   out_bin_q, out_bin_d;
  logic           out_wrap_q, out_wrap_d;
  logic           out_err_q, out_err_d;

  logic             stall;
  logic [TCW-1:0]   base_tc;
  logic [2*TCW-1:0] sum_ext;
  logic [2*TCW-1:0] res_ext;
  logic [TCW-1:0]   res_tc;
  logic [W-1:0]     res_bin;
  logic             res_wrap;

  tc_encode #(.M(M)) u_enc (
    .bin (in_data),
    .tc  (enc_tc),
    .err (enc_err)
  );

  assign stall    = out_vld_q && !out_ready;
  assign in_ready = !stall;

  // out_tc_q doubles as the accumulator
  always_comb begin
    base_tc = s1_clr_q ? '0 : out_tc_q;
    sum_ext = {{TCW{1'b0}}, base_tc};
    for (int i = 0; i < TCW; i++) begin
      if (s1_tc_q[i]) begin
        sum_ext = {sum_ext[2*TCW-2:0], 1'b1};
      end
    end
    res_wrap = sum_ext[TCW];
    res_ext  = res_wrap ? (sum_ext >> M) : sum_ext;
    res_tc   = res_ext[TCW-1:0];
    res_bin  = '0;
    for (int i = 0; i < TCW; i++) begin
      res_bin = res_bin + W'(res_tc[i]);
    end
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_tc_d    = s1_tc_q;
    s1_clr_d   = s1_clr_q;
    s1_err_d   = s1_err_q;
    out_vld_d  = out_vld_q;
    out_tc_d   = out_tc_q;
    out_bin_d  = out_bin_q;
    out_wrap_d = out_wrap_q;
    out_err_d  = out_err_q;
    if (!stall) begin
      s1_vld_d  = in_valid;
      s1_tc_d   = enc_tc;
      s1_clr_d  = in_clr;
      s1_err_d  = enc_err;
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_tc_d   = res_tc;
        out_bin_d  = res_bin;
        out_wrap_d = res_wrap;
        out_err_d  = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_tc_q    <= '0;
      s1_clr_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_tc_q   <= '0;
      out_bin_q  <= '0;
      out_wrap_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_tc_q    <= s1_tc_d;
      s1_clr_q   <= s1_clr_d;
      s1_err_q   <= s1_err_d;
      out_vld_q  <= out_vld_d;
      out_tc_q   <= out_tc_d;
      out_bin_q  <= out_bin_d;
      out_wrap_q <= out_wrap_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_tc    = out_tc_q;
  assign out_bin   = out_bin_q;
  assign out_wrap  = out_wrap_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_tc_mod_acc.sv
// Scoreboard bench for tc_mod_acc with three
// instances: M=11 directed, M=3 and M=64 random.
module tb_tc_mod_acc;

  typedef struct {
    int res;
    bit wrap;
    bit err;
  } exp_t;

  int mods[3] = '{11, 3, 64};
  int wds[3]  = '{4, 2, 6};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv, cl, ordy, ir, ov, wo, eo;

  logic [3:0]  d0;
  logic [1:0]  d1;
  logic [5:0]  d2;
  logic [9:0]  tc0;
  logic [1:0]  tc1;
  logic [62:0] tc2;
  logic [3:0]  bn0;
  logic [1:0]  bn1;
  logic [5:0]  bn2;

  logic [62:0] tco[3];
  logic [6:0]  bno[3];

  exp_t sb[3][256];
  int   wp[3], rp[3];
  int   acc[3];

  bit          st_prev[3];
  logic [62:0] htc[3];
  logic [6:0]  hbn[3];
  logic        hw[3], he[3];

  int errors = 0;
  int checks = 0;
  bit done;

  always #5 clk = ~clk;

  tc_mod_acc #(.M(11)) u_m11 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(d0), .in_clr(cl[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_tc(tc0), .out_bin(bn0),
    .out_wrap(wo[0]), .out_err(eo[0])
  );

  tc_mod_acc #(.M(3)) u_m3 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(d1), .in_clr(cl[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_tc(tc1), .out_bin(bn1),
    .out_wrap(wo[1]), .out_err(eo[1])
  );

  tc_mod_acc #(.M(64)) u_m64 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(d2), .in_clr(cl[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_tc(tc2), .out_bin(bn2),
    .out_wrap(wo[2]), .out_err(eo[2])
  );

  always_comb begin
    tco[0] = 63'(tc0);
    tco[1] = 63'(tc1);
    tco[2] = tc2;
    bno[0] = 7'(bn0);
    bno[1] = 7'(bn1);
    bno[2] = 7'(bn2);
  end

  task automatic chk(input string nm, input int k,
                     input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s M=%0d actual=%0h required=%0h",
               nm, mods[k], act, exp);
    end
  endtask

  task automatic set_data(input int k, input int v);
    case (k)
      0: d0 = 4'(v);
      1: d1 = 2'(v);
      default: d2 = 6'(v);
    endcase
  endtask

  task automatic send(input int k, input int data, input bit c);
    int n, base, add, s, m;
    exp_t e;
    iv[k] = 1'b1;
    cl[k] = c;
    set_data(k, data);
    @(negedge clk);
    n = 0;
    while (!ir[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) begin
      chk("send_timeout", k, 0, 1);
      iv[k] = 1'b0;
      return;
    end
    m     = mods[k];
    e.err = data >= m;
    add   = e.err ? 0 : data;
    base  = c ? 0 : acc[k];
    s     = base + add;
    e.wrap = s >= m;
    e.res  = e.wrap ? s - m : s;
    acc[k] = e.res;
    sb[k][wp[k] % 256] = e;
    wp[k]++;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        st_prev[k] = 1'b0;
      end else begin
        if (st_prev[k]) begin
          chk("hold_valid", k, longint'(ov[k]), 1);
          chk("hold_tc", k, longint'(tco[k]), longint'(htc[k]));
          chk("hold_bin", k, longint'(bno[k]), longint'(hbn[k]));
          chk("hold_wrap", k, longint'(wo[k]), longint'(hw[k]));
          chk("hold_err", k, longint'(eo[k]), longint'(he[k]));
        end
        if (ov[k] && !ordy[k]) begin
          chk("stall_in_ready", k, longint'(ir[k]), 0);
          st_prev[k] = 1'b1;
          htc[k] = tco[k];
          hbn[k] = bno[k];
          hw[k]  = wo[k];
          he[k]  = eo[k];
        end else begin
          st_prev[k] = 1'b0;
        end
        if (ov[k] && ordy[k]) begin
          if (rp[k] == wp[k]) begin
            chk("unexpected_beat", k, 1, 0);
          end else begin
            exp_t e;
            logic [63:0] t;
            e = sb[k][rp[k] % 256];
            rp[k]++;
            t = (64'd1 << e.res) - 64'd1;
            chk("out_bin", k, longint'(bno[k]), longint'(e.res));
            chk("out_tc", k, longint'(tco[k]), longint'(t[62:0]));
            chk("out_wrap", k, longint'(wo[k]), longint'(e.wrap));
            chk("out_err", k, longint'(eo[k]), longint'(e.err));
            chk("popcount", k, longint'($countones(tco[k])),
                longint'(bno[k]));
          end
        end
      end
    end
  end

  task automatic drain(input int k);
    int n;
    n = 0;
    while (rp[k] != wp[k] && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", k, longint'(wp[k] - rp[k]), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rp[k]  = wp[k];
      acc[k] = 0;
    end
  endtask

  initial begin
    iv = '0; cl = '0; ordy = '1;
    d0 = '0; d1 = '0; d2 = '0;
    for (int k = 0; k < 3; k++) begin
      wp[k] = 0; rp[k] = 0; acc[k] = 0;
      st_prev[k] = 1'b0;
    end
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", k, longint'(ov[k]), 0);
      chk("rst_in_ready", k, longint'(ir[k]), 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_tc", k, longint'(tco[k]), 0);
      chk("rst_bin", k, longint'(bno[k]), 0);
      chk("rst_wrap_err", k, longint'({wo[k], eo[k]}), 0);
      chk("post_rst_in_ready", k, longint'(ir[k]), 1);
    end
    @(posedge clk);
    #1;

    send(0, 3, 1'b1);
    @(negedge clk);
    chk("latency_early", 0, longint'(ov[0]), 0);
    @(negedge clk);
    chk("latency_hit", 0, longint'(ov[0]), 1);
    @(posedge clk);
    #1;
    send(0, 4, 1'b0);
    send(0, 5, 1'b0);
    send(0, 10, 1'b1);
    send(0, 10, 1'b0);
    send(0, 6, 1'b1);
    send(0, 13, 1'b0);
    send(0, 2, 1'b0);
    send(0, 15, 1'b1);
    send(0, 9, 1'b0);
    drain(0);

    ordy[0] = 1'b0;
    send(0, 1, 1'b1);
    send(0, 2, 1'b0);
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
      begin
        send(0, 3, 1'b0);
        send(0, 4, 1'b0);
        send(0, 8, 1'b0);
      end
    join
    drain(0);

    ordy[0] = 1'b0;
    send(0, 7, 1'b1);
    send(0, 2, 1'b0);
    do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", 0, longint'(ov[0]), 0);
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    send(0, 5, 1'b0);
    send(0, 9, 1'b0);
    drain(0);

    for (int k = 1; k < 3; k++) begin
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 300; i++) begin
            send(k, int'($urandom_range(0, (1 << wds[k]) - 1)),
                 $urandom_range(0, 7) == 0);
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            ordy[k] = $urandom_range(0, 3) != 0;
          end
          ordy[k] = 1'b1;
        end
      join
      drain(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
